// File: rtl/vedic_pkg.sv
// Shared constants and FSM encoding for the vedic multiplier datapath.
package vedic_pkg;

   localparam int DEF_PROD_W  = 64;
   localparam int DEF_GUARD_W = 8;
   localparam int DEF_ACC_W   = DEF_PROD_W + DEF_GUARD_W;
   localparam int DEF_CNT_W   = 16;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } acc_state_e;

endpackage

// File: rtl/vedic_product_acc_if.sv
// Product-in / result-out handshake bundle for vedic_product_acc.
interface vedic_product_acc_if
   import vedic_pkg::*;
#(
   parameter int PROD_W  = DEF_PROD_W,
   parameter int GUARD_W = DEF_GUARD_W,
   parameter int CNT_W   = DEF_CNT_W
);
   localparam int ACC_W = PROD_W + GUARD_W;

   logic              prod_valid;
   logic              prod_ready;
   logic [PROD_W-1:0] product;
   logic              prod_last;
   logic              acc_valid;
   logic              acc_ready;
   logic [ACC_W-1:0]  acc_sum;
   logic [CNT_W-1:0]  acc_count;
   logic              acc_ovf;

   // master: product source and result sink; slave: the accumulator
   modport master (
      output prod_valid, product, prod_last, acc_ready,
      input  prod_ready, acc_valid, acc_sum, acc_count, acc_ovf
   );

   modport slave (
      input  prod_valid, product, prod_last, acc_ready,
      output prod_ready, acc_valid, acc_sum, acc_count, acc_ovf
   );

endinterface

// File: rtl/acc_add.sv
// ACC_W-bit ripple-carry adder from half/full adder cells; carry-out feeds overflow.
module acc_add
   import vedic_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             cout
);
   logic [ACC_W:1] c;

   half_add u_ha (.a(a[0]), .b(b[0]), .s(sum[0]), .co(c[1]));

   for (genvar i = 1; i < ACC_W; i++) begin : g_fa
      full_add u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
   end

   assign cout = c[ACC_W];
endmodule

// File: rtl/full_add.sv
// One-bit full adder cell.
module full_add (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/half_add.sv
// One-bit half adder cell.
module half_add (
   input  logic a,
   input  logic b,
   output logic s,
   output logic co
);
   assign s  = a ^ b;
   assign co = a & b;
endmodule

// File: rtl/vedic_product_acc.sv
// Streaming frame accumulator for vedic_32x32 products: registered valid/ready
// input, guarded sum with sticky overflow, saturating term count, held result.
module vedic_product_acc
   import vedic_pkg::*;
#(
   parameter int PROD_W  = DEF_PROD_W,
   parameter int GUARD_W = DEF_GUARD_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                acc_clear,
   vedic_product_acc_if.slave  bus
);
   localparam int ACC_W = PROD_W + GUARD_W;

   acc_state_e       state, state_next;
   logic [ACC_W-1:0] acc, acc_next, add_sum, sum_q;
   logic [CNT_W-1:0] cnt, cnt_next, cnt_q;
   logic             ovf, ovf_next, ovf_q;
   logic             add_cout, ready_q, load_out, hs;

   acc_add #(.ACC_W(ACC_W)) u_add (
      .a    (acc),
      .b    ({{GUARD_W{1'b0}}, bus.product}),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign hs = bus.prod_valid & ready_q;

   // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      acc_next   = acc;
      cnt_next   = cnt;
      ovf_next   = ovf;
      load_out   = 1'b0;
      if (acc_clear) begin
         state_next = ST_ACCUM;
         acc_next   = '0;
         cnt_next   = '0;
         ovf_next   = 1'b0;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (hs) begin
                  acc_next = add_sum;
                  cnt_next = (&cnt) ? cnt : cnt + 1'b1;
                  ovf_next = ovf | add_cout;
                  if (bus.prod_last) begin
                     state_next = ST_HOLD;
                     load_out   = 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (bus.acc_ready) begin
                  state_next = ST_ACCUM;
                  acc_next   = '0;
                  cnt_next   = '0;
                  ovf_next   = 1'b0;
               end
            end
            default: state_next = ST_ACCUM;
         endcase
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_ACCUM;
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         ready_q <= 1'b0;
         sum_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state   <= state_next;
         acc     <= acc_next;
         cnt     <= cnt_next;
         ovf     <= ovf_next;
         // ready is a registered copy of "next state is ACCUM", low through reset
         ready_q <= (state_next == ST_ACCUM);
         if (acc_clear) begin
            sum_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else if (load_out) begin
            sum_q <= acc_next;
            cnt_q <= cnt_next;
            ovf_q <= ovf_next;
         end
      end
   end

   assign bus.prod_ready = ready_q;
   assign bus.acc_valid  = (state == ST_HOLD);
   assign bus.acc_sum    = sum_q;
   assign bus.acc_count  = cnt_q;
   assign bus.acc_ovf    = ovf_q;

endmodule
